// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid.
// master drives payload in and accepts output; slave is the stage.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport master (
    output in_valid_i,
    input  in_ready_o,
    output in_data_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o
  );

  modport slave (
    input  in_valid_i,
    output in_ready_o,
    input  in_data_i,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with one-entry skid buffer and flush.
// Optional stall counter: define PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  pipe_stage_skid_if.slave io,
  output logic [1:0]  occupancy_o,
  output logic [31:0] stall_cnt_o
);

  logic              r_main_v;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Ready depends only on registered skid state, except for flush.
  assign w_ready = rst_i & ~r_skid_v & ~flush_i;
  assign w_push  = io.in_valid_i & w_ready;
  assign w_pop   = r_main_v & io.out_ready_i;

  assign io.in_ready_o  = w_ready;
  assign io.out_valid_o = r_main_v;
  assign io.out_data_o  = r_main_d;
  assign occupancy_o    = {1'b0, r_main_v} + {1'b0, r_skid_v};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      priority case (1'b1)
        flush_i: begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
          r_main_d <= FLUSH_VAL;
        end
        (r_skid_v & w_pop): begin
          r_main_d <= r_skid_d;
          r_main_v <= 1'b1;
          r_skid_v <= 1'b0;
        end
        r_skid_v: begin
        end
        (~r_main_v & w_push): begin
          r_main_d <= io.in_data_i;
          r_main_v <= 1'b1;
        end
        (w_pop & w_push): begin
          r_main_d <= io.in_data_i;
        end
        w_pop: begin
          r_main_v <= 1'b0;
        end
        w_push: begin
          r_skid_d <= io.in_data_i;
          r_skid_v <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (r_main_v & ~io.out_ready_i
                 & (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
